// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with start/busy/done handshake.
// Optional saturation/overflow flag enabled by defining BCD_RANGE_CHECK_EN.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf
);

  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_reg, state_next;
  logic [SR_W-1:0]       sr_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  done_reg;
  logic [4*DIGITS-1:0]   bcd_reg;
  logic [DIGITS-1:0]     blank_reg;

  logic [SR_W-1:0]       adj;
  logic [SR_W-1:0]       shifted;
  logic [4*DIGITS-1:0]   result;
  logic [4*DIGITS-1:0]   res_out;
  logic [DIGITS-1:0]     blank_calc;
  logic                  accept;
  logic                  last_shift;
  logic                  unused_msb;

  assign accept     = (state_reg == IDLE) && start;
  assign last_shift = (state_reg == SHIFT) && (cnt_reg == CNT_W'(BIN_W - 1));

  // Add-3 correction on every digit of the working field, including the spare top digit.
  assign adj[BIN_W-1:0] = sr_reg[BIN_W-1:0];
  for (genvar gi = 0; gi <= DIGITS; gi++) begin : g_adj
    logic [3:0] dig;
    assign dig = sr_reg[BIN_W + 4*gi +: 4];
    assign adj[BIN_W + 4*gi +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
  end

  assign shifted    = {adj[SR_W-2:0], 1'b0};
  assign result     = shifted[BIN_W +: 4*DIGITS];
  assign unused_msb = adj[SR_W-1];

  // Digit i blanks when it and every higher output digit are zero; units never blank.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_units
      assign blank_calc[gi] = 1'b0;
    end else begin : g_upper
      assign blank_calc[gi] = ~|res_out[4*DIGITS-1:4*gi];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_reg == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg    <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      bcd_reg   <= '0;
      blank_reg <= BLANK_RST;
    end else begin
      done_reg <= last_shift;
      if (accept) begin
        sr_reg  <= {{BCD_W{1'b0}}, bin};
        cnt_reg <= '0;
      end else if (state_reg == SHIFT) begin
        sr_reg  <= shifted;
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (last_shift) begin
        bcd_reg   <= res_out;
        blank_reg <= blank_calc;
      end
    end
  end

`ifdef BCD_RANGE_CHECK_EN
  localparam int MAX_VAL = (10 ** DIGITS) - 1;

  logic ovf_pend_reg;
  logic ovf_reg;

  // Out-of-range inputs are flagged at accept time and saturate to all nines at done.
  assign res_out = ovf_pend_reg ? {DIGITS{4'h9}} : result;
  assign ovf     = ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      if (accept)     ovf_pend_reg <= (32'(bin) > MAX_VAL);
      if (last_shift) ovf_reg      <= ovf_pend_reg;
    end
  end
`else
  assign res_out = result;
  assign ovf     = 1'b0;
`endif

  assign done  = done_reg;
  assign bcd   = bcd_reg;
  assign blank = blank_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: an 8-bit/3-digit instance and an 8-bit/2-digit instance.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [7:0]  bin, bin2;
  logic        busy, done, ovf;
  logic [11:0] bcd;
  logic [2:0]  blank;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
  logic [1:0]  blank2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank), .ovf(ovf)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .blank(blank2), .ovf(ovf2)
  );

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; bin = '0; start2 = 1'b0; bin2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (bcd !== 12'h000) begin failures++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
    checks++; if (blank !== 3'b110) begin failures++; $display("FAIL reset_blank got=%b exp=110", blank); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (blank2 !== 2'b10) begin failures++; $display("FAIL reset_blank2 got=%b exp=10", blank2); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: busy=%b done=%b bcd=%h blank=%b ovf=%b", busy, done, bcd, blank, ovf);
  endtask

  task automatic test_convert(input logic [7:0] val, input logic [11:0] exp_bcd,
                              input logic [2:0] exp_blank);
    int n;
    bit unstable;
    logic [11:0] prev;
    prev = bcd;
    unstable = 0;
    start = 1'b1; bin = val;
    @(posedge clk); #1;
    start = 1'b0; bin = ~val;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL conv_busy_%0d got=%b exp=1", val, busy); end
    n = 0;
    while (n < 20 && done !== 1'b1) begin
      if (bcd !== prev) unstable = 1;
      @(posedge clk); #1;
      n++;
    end
    checks++; if (unstable) begin failures++; $display("FAIL conv_stable_%0d got=changed exp=held", val); end
    checks++; if (n != 8) begin failures++; $display("FAIL conv_latency_%0d got=%0d exp=8", val, n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL conv_busy_done_%0d got=%b exp=0", val, busy); end
    checks++; if (bcd !== exp_bcd) begin failures++; $display("FAIL conv_bcd_%0d got=%h exp=%h", val, bcd, exp_bcd); end
    checks++; if (blank !== exp_blank) begin failures++; $display("FAIL conv_blank_%0d got=%b exp=%b", val, blank, exp_blank); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL conv_ovf_%0d got=%b exp=0", val, ovf); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL conv_done_pulse_%0d got=%b exp=0", val, done); end
    $display("convert: bin=%0d latency=%0d bcd=%h blank=%b ovf=%b", val, n, bcd, blank, ovf);
  endtask

  task automatic test_busy_ignore;
    int n;
    int extra_done;
    start = 1'b1; bin = 8'd49;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    repeat (2) begin @(posedge clk); #1; n++; end
    start = 1'b1; bin = 8'd200;
    @(posedge clk); #1; n++;
    start = 1'b0;
    while (n < 20 && done !== 1'b1) begin @(posedge clk); #1; n++; end
    checks++; if (n != 8) begin failures++; $display("FAIL ignore_latency got=%0d exp=8", n); end
    checks++; if (bcd !== 12'h049) begin failures++; $display("FAIL ignore_bcd got=%h exp=049", bcd); end
    extra_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    checks++; if (extra_done != 0) begin failures++; $display("FAIL ignore_second_done got=%0d exp=0", extra_done); end
    $display("busy_ignore: latency=%0d bcd=%h extra_activity=%0d", n, bcd, extra_done);
  endtask

  task automatic test_back_to_back;
    int n;
    start = 1'b1; bin = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < 20 && done !== 1'b1) begin @(posedge clk); #1; n++; end
    checks++; if (bcd !== 12'h007) begin failures++; $display("FAIL b2b_first_bcd got=%h exp=007", bcd); end
    checks++; if (blank !== 3'b110) begin failures++; $display("FAIL b2b_first_blank got=%b exp=110", blank); end
    start = 1'b1; bin = 8'd123;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
    while (n < 20 && done !== 1'b1) begin @(posedge clk); #1; n++; end
    checks++; if (n != 9) begin failures++; $display("FAIL b2b_spacing got=%0d exp=9", n); end
    checks++; if (bcd !== 12'h123) begin failures++; $display("FAIL b2b_bcd got=%h exp=123", bcd); end
    checks++; if (blank !== 3'b000) begin failures++; $display("FAIL b2b_blank got=%b exp=000", blank); end
    $display("back_to_back: spacing=%0d bcd=%h blank=%b", n, bcd, blank);
  endtask

  task automatic test_reset_mid;
    int seen;
    start = 1'b1; bin = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (bcd !== 12'h000) begin failures++; $display("FAIL rstmid_bcd got=%h exp=000", bcd); end
    checks++; if (blank !== 3'b110) begin failures++; $display("FAIL rstmid_blank got=%b exp=110", blank); end
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
    $display("reset_mid: busy=%b bcd=%h blank=%b activity=%0d", busy, bcd, blank, seen);
    test_convert(8'd49, 12'h049, 3'b100);
  endtask

  task automatic test_two_digit(input logic [7:0] val, input logic [7:0] exp_bcd,
                                input logic [1:0] exp_blank, input logic exp_ovf);
    int n;
    start2 = 1'b1; bin2 = val;
    @(posedge clk); #1;
    start2 = 1'b0; bin2 = '0;
    n = 0;
    while (n < 20 && done2 !== 1'b1) begin @(posedge clk); #1; n++; end
    checks++; if (n != 8) begin failures++; $display("FAIL d2_latency_%0d got=%0d exp=8", val, n); end
    checks++; if (bcd2 !== exp_bcd) begin failures++; $display("FAIL d2_bcd_%0d got=%h exp=%h", val, bcd2, exp_bcd); end
    checks++; if (blank2 !== exp_blank) begin failures++; $display("FAIL d2_blank_%0d got=%b exp=%b", val, blank2, exp_blank); end
    checks++; if (ovf2 !== exp_ovf) begin failures++; $display("FAIL d2_ovf_%0d got=%b exp=%b", val, ovf2, exp_ovf); end
    @(posedge clk); #1;
    $display("two_digit: bin=%0d latency=%0d bcd=%h blank=%b ovf=%b", val, n, bcd2, blank2, ovf2);
  endtask

  initial begin
    test_reset();
    test_convert(8'd49,  12'h049, 3'b100);
    test_convert(8'd255, 12'h255, 3'b000);
    test_convert(8'd0,   12'h000, 3'b110);
    test_convert(8'd100, 12'h100, 3'b000);
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef BCD_RANGE_CHECK_EN
    test_two_digit(8'd150, 8'h99, 2'b00, 1'b1);
`else
    test_two_digit(8'd150, 8'h50, 2'b00, 1'b0);
`endif
    test_two_digit(8'd99, 8'h99, 2'b00, 1'b0);
    test_two_digit(8'd5,  8'h05, 2'b10, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
Sits directly upstream of the 4-digit seven-segment scan driver. It replaces that driver's combinational converter and feeds it registered BCD digits plus a leading-zero blank mask.
A start/busy/done handshake lets any producer (counter, sensor, UART) request a conversion.

Parameters:
BIN_W, 8, width of binary input; legal range 4..16
DIGITS, 3, number of BCD output digits; legal range 1..5

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request; sampled only in IDLE
bin  input  BIN_W  unsigned binary value; sampled on the edge that accepts start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; bcd/blank/ovf valid and updated
bcd  output  4*DIGITS  packed BCD result, digit 0 = bcd[3:0] (units); held until next done
blank  output  DIGITS  blank[i]=1 when digit i and all higher digits are 0; blank[0] always 0
ovf  output  1  range flag (see Optional Feature); held with bcd

Behaviour:
- Reset: clk and rst_n as decided (rst_n asynchronous, active-low; clock clk). Asserting rst_n forces FSM=IDLE, busy=0, done=0, bcd=0, blank={DIGITS-1 ones, 0}, ovf=0, bit counter=0, shift register=0.
- FSM states: IDLE, SHIFT.
- IDLE + start=1 at edge E0:
  - latch bin into the binary field; clear the BCD field; counter=0.
  - busy=1; go to SHIFT.
- IDLE + start=0: remain in IDLE.
- SHIFT, each edge:
  - for every 4-bit digit of the working BCD field: if the digit is ≥5, add 3.
  - then shift {BCD field, binary field} left by 1.
  - counter increments.
- The working BCD field has DIGITS+1 digits internally, so digits above DIGITS are never lost mid-algorithm. Only the low DIGITS digits are output.
- Final shift (counter==BIN_W-1) at edge E0+BIN_W:
  - the combinational next value is registered directly into bcd; blank and ovf are updated on the same edge.
  - done=1 for exactly one cycle; busy=0; FSM→IDLE.
- Latency: done high in the cycle following edge E0+BIN_W. For BIN_W=8, done is observed 8 edges after the accepting edge.
- start while busy=1: ignored; no queueing; bin is not resampled.
- start during the done cycle: accepted (FSM is already IDLE). Back-to-back conversions give a throughput of one per BIN_W+1 cycles.
- bcd/blank/ovf change only on the done edge or on reset. They remain stable during conversion, so the downstream scan driver never sees partial results.
- blank is computed from the registered result. If value=0, blank={DIGITS-1 ones, 0}.
- Reset mid-conversion: immediate abort, all outputs return to reset values, no done pulse.

Optional Feature:
Macro BCD_RANGE_CHECK_EN.
- Defined:
  - on accepting start, compare bin against 10^DIGITS-1 (elaboration-time constant).
  - if greater: the result saturates to all digits = 9, blank=0, ovf=1 at done.
  - otherwise ovf=0.
  - latency unchanged.
- Undefined:
  - no comparator; ovf tied to 0.
  - an out-of-range value outputs its low DIGITS decimal digits (truncation).

Test Plan:
- BIN_W=8, DIGITS=3; bin=49, start pulse → done 8 edges later, bcd=12'h049, blank=3'b100, ovf=0, busy low the same edge done rises.
- bin=255 → bcd=12'h255, blank=3'b000; bin=0 → bcd=12'h000, blank=3'b110; bin=100 → bcd=12'h100, blank=3'b000.
- start with bin=49; at edge 3 assert start with bin=200 → single done, bcd=12'h049, no second done.
- bin=7 conversion, then start with bin=123 in the done cycle → second done exactly 9 cycles after the first, bcd=12'h123.
- Reset mid-conversion: bin=200 started, rst_n low at edge 4 → busy=0, done never pulses, bcd=0, blank=3'b110; a new conversion after release is correct.
- BIN_W=8, DIGITS=2; bin=150 → with BCD_RANGE_CHECK_EN: bcd=8'h99, ovf=1; without: bcd=8'h50, ovf=0. bin=99 → bcd=8'h99, ovf=0 in both builds.
